uart_tx_arbiter: RTL

- Shares one uart_tx instance between NUM_REQ byte producers, e.g. the echo FSM, a status reporter and a debug dumper.
- Round-robin arbitration with a message lock: once a requester wins, it keeps the transmitter until it flags the last byte, so multi-byte lines never interleave.
- Drives uart_tx i_tx_valid/tx_message and sequences each byte off uart_tx done.
- A watchdog recovers from a stalled transmitter or an abandoned message.

---
 rtl/uart_tx_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte producers.
// Round-robin grant with a message lock, per-byte sequencing off tx_done,
// and a watchdog that recovers from a stalled frame or abandoned message.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_valid/data/last  per-requester byte offer (data i on [8i+7:8i])
//   req_ready            per-requester accept (transfer on valid & ready)
//   tx_valid, tx_data    start pulse and byte to uart_tx
//   tx_active, tx_done   busy level and frame-end pulse from uart_tx
//   grant_id             current or last granted requester
//   busy                 high whenever not arbitrating
//   err_timeout          sticky watchdog flag, cleared only by reset
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ID_W        = 1,
    parameter int TIMEOUT_CYC = 200_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ARB, START, WAIT_DONE, HOLD
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant_id;
    logic              r_locked;
    logic [7:0]        r_tx_data;
    logic              r_err;
    logic [WD_W-1:0]   r_wd;

    logic              w_any;
    logic [ID_W-1:0]   w_sel;
    logic [ID_W-1:0]   w_cur;
    logic              w_xfer;
    logic              w_wd_exp;
    logic [7:0]        w_xdata;
    logic              w_xlast;
    logic [ID_W-1:0]   w_rr_nxt;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        logic [ID_W-1:0] idx;
        w_any = 1'b0;
        w_sel = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_any && req_valid[idx]) begin
                w_any = 1'b1;
                w_sel = idx;
            end
        end
    end

    // In HOLD only the locked owner may transfer.
    assign w_cur    = (r_state == HOLD) ? r_grant_id : w_sel;
    assign w_xdata  = req_data[{w_cur, 3'b000} +: 8];
    assign w_xlast  = req_last[w_cur];
    assign w_wd_exp = (r_wd == WD_W'(TIMEOUT_CYC - 1));
    assign w_rr_nxt = (r_grant_id == ID_W'(NUM_REQ - 1)) ?
                      '0 : r_grant_id + 1'b1;

    always_comb begin
        w_xfer = 1'b0;
        unique case (r_state)
            ARB:     w_xfer = !tx_active && w_any;
            HOLD:    w_xfer = req_valid[r_grant_id];
            default: w_xfer = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ARB;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB: if (w_xfer) w_state_nxt = START;
            START: w_state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (tx_done)
                    w_state_nxt = r_locked ? HOLD : ARB;
                else if (w_wd_exp)
                    w_state_nxt = ARB;
            end
            HOLD: begin
                if (w_xfer)        w_state_nxt = START;
                else if (w_wd_exp) w_state_nxt = ARB;
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            ARB: begin
                busy = 1'b0;
                if (!tx_active && w_any) req_ready[w_sel] = 1'b1;
            end
            START: tx_valid = 1'b1;
            HOLD:  req_ready[r_grant_id] = 1'b1;
            default: ;
        endcase
    end

    // Datapath: byte latch, grant, lock, pointer and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_locked   <= 1'b0;
            r_tx_data  <= 8'h00;
            r_err      <= 1'b0;
            r_wd       <= '0;
        end else begin
            unique case (r_state)
                ARB: begin
                    if (w_xfer) begin
                        r_tx_data  <= w_xdata;
                        r_grant_id <= w_sel;
                        r_locked   <= ~w_xlast;
                    end
                end
                START: r_wd <= '0;
                WAIT_DONE: begin
                    if (tx_done) begin
                        r_wd <= '0;
                        if (!r_locked) r_rr_ptr <= w_rr_nxt;
                    end else if (w_wd_exp) begin
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        r_rr_ptr <= w_rr_nxt;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                HOLD: begin
                    if (w_xfer) begin
                        r_tx_data <= w_xdata;
                        r_locked  <= ~w_xlast;
                    end else if (w_wd_exp) begin
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        r_rr_ptr <= w_rr_nxt;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign err_timeout = r_err;

endmodule
